// File: rtl/special_color_pipe_if.sv
// special_color_pipe_if: pixel-in / colour-out handshake bundle for special_color_pipe.
interface special_color_pipe_if #(
   parameter int CH_W   = 5,
   parameter int NUM_CH = 3
);
   logic                   pix_valid, pix_ready, top_semi, win_fx;
   logic [2:0]             top_id, bot_id;
   logic [NUM_CH*CH_W-1:0] color0, color1, out_color;
   logic                   out_valid, out_ready;
   modport master (
      output pix_valid, top_id, bot_id, top_semi, win_fx, color0, color1, out_ready,
      input  pix_ready, out_valid, out_color
   );
   modport slave (
      input  pix_valid, top_id, bot_id, top_semi, win_fx, color0, color1, out_ready,
      output pix_ready, out_valid, out_color
   );
endinterface

// File: rtl/special_color_pipe.sv
// special_color_pipe: 3-stage blend/brighten/darken colour effect pipeline with shadowed config.
// Optional blend statistics counter enabled by SPECIAL_COLOR_PIPE_STATS_EN.
module special_color_pipe #(
   parameter int CH_W   = 5,
   parameter int NUM_CH = 3,
   parameter int COEF_W = 5
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [2:0]           cfg_we,
   input  logic [15:0]          cfg_data,
   input  logic                 line_start,
   special_color_pipe_if.slave  px,
   output logic [15:0]          blend_count
);
   localparam int W   = NUM_CH * CH_W;
   localparam int P_W = CH_W + 5;
   localparam logic [CH_W-1:0] MAX = '1;
   typedef enum logic [1:0] {FX_NONE, FX_ALPHA, FX_BRIGHT, FX_DARK} fx_t;
   logic [15:0]           sh_cnt_q, sh_cnt_d, sh_alpha_q, sh_alpha_d, sh_y_q, sh_y_d;
   logic [15:0]           ac_cnt_q, ac_cnt_d, ac_alpha_q, ac_alpha_d, ac_y_q, ac_y_d;
   logic                  v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
   fx_t                   fx1_q, fx1_d, fx2_q, fx2_d;
   logic [4:0]            eva1_q, eva1_d, evb1_q, evb1_d, evy1_q, evy1_d;
   logic [W-1:0]          a1_q, a1_d, b1_q, b1_d, a2_q, a2_d, out_q, out_d;
   logic [NUM_CH*P_W-1:0] p0_q, p0_d, p1_q, p1_d;
   logic                  adv, t1, t2, unused_act;
   logic [1:0]            mode;
   logic [CH_W-1:0]       ca, cb, cc;
   logic [4:0]            c0;
   logic [P_W-1:0]        q0;
   logic [P_W:0]          sum;
   function automatic logic [4:0] sat16(input logic [COEF_W-1:0] f);
      return (32'(f) > 32'd16) ? 5'd16 : 5'(f);
   endfunction
   assign unused_act = ^{ac_cnt_q, ac_alpha_q, ac_y_q};
   always_comb begin
      adv        = ~v3_q | px.out_ready;
      sh_cnt_d   = cfg_we[0] ? cfg_data : sh_cnt_q;
      sh_alpha_d = cfg_we[1] ? cfg_data : sh_alpha_q;
      sh_y_d     = cfg_we[2] ? cfg_data : sh_y_q;
      // a write landing with line_start goes straight through to the active copy
      ac_cnt_d   = line_start ? sh_cnt_d : ac_cnt_q;
      ac_alpha_d = line_start ? sh_alpha_d : ac_alpha_q;
      ac_y_d     = line_start ? sh_y_d : ac_y_q;
      mode       = ac_cnt_q[7:6];
      t1         = px.top_id < 3'd6 && ac_cnt_q[{1'b0, px.top_id}];
      t2         = px.bot_id < 3'd6 && ac_cnt_q[{1'b1, px.bot_id}];
      fx1_d      = (px.top_semi && t2) ? FX_ALPHA : !(t1 && px.win_fx) ? FX_NONE :
                   mode == 2'd1 ? (t2 ? FX_ALPHA : FX_NONE) : fx_t'(mode);
      eva1_d     = sat16(ac_alpha_q[COEF_W-1:0]);
      evb1_d     = sat16(ac_alpha_q[8 +: COEF_W]);
      evy1_d     = sat16(ac_y_q[COEF_W-1:0]);
      v1_d       = px.pix_valid;
      a1_d       = px.color0;
      b1_d       = px.color1;
      v2_d       = v1_q;
      fx2_d      = fx1_q;
      a2_d       = a1_q;
      v3_d       = v2_q;
      p0_d = '0; p1_d = '0; out_d = '0;
      ca = '0; cb = '0; cc = '0; c0 = '0; q0 = '0; sum = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         ca = a1_q[k*CH_W +: CH_W];
         cb = b1_q[k*CH_W +: CH_W];
         c0 = fx1_q == FX_ALPHA ? eva1_q : evy1_q;
         p0_d[k*P_W +: P_W] = P_W'(fx1_q == FX_BRIGHT ? MAX - ca : ca) * P_W'(c0);
         p1_d[k*P_W +: P_W] = P_W'(cb) * P_W'(evb1_q);
         cc  = a2_q[k*CH_W +: CH_W];
         q0  = p0_q[k*P_W +: P_W] >> 4;
         sum = ({1'b0, p0_q[k*P_W +: P_W]} + {1'b0, p1_q[k*P_W +: P_W]}) >> 4;
         out_d[k*CH_W +: CH_W] = fx2_q == FX_ALPHA  ? (sum > (P_W+1)'(MAX) ? MAX : sum[CH_W-1:0]) :
                                 fx2_q == FX_BRIGHT ? cc + q0[CH_W-1:0] :
                                 fx2_q == FX_DARK   ? cc - q0[CH_W-1:0] : cc;
      end
   end
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         sh_cnt_q <= '0; sh_alpha_q <= '0; sh_y_q <= '0;
         ac_cnt_q <= '0; ac_alpha_q <= '0; ac_y_q <= '0;
         v1_q <= 1'b0; v2_q <= 1'b0; v3_q <= 1'b0;
         fx1_q <= FX_NONE; fx2_q <= FX_NONE;
         eva1_q <= '0; evb1_q <= '0; evy1_q <= '0;
         a1_q <= '0; b1_q <= '0; a2_q <= '0; p0_q <= '0; p1_q <= '0; out_q <= '0;
      end else begin
         sh_cnt_q <= sh_cnt_d; sh_alpha_q <= sh_alpha_d; sh_y_q <= sh_y_d;
         ac_cnt_q <= ac_cnt_d; ac_alpha_q <= ac_alpha_d; ac_y_q <= ac_y_d;
         if (adv) begin
            v1_q <= v1_d; fx1_q <= fx1_d; eva1_q <= eva1_d; evb1_q <= evb1_d; evy1_q <= evy1_d;
            a1_q <= a1_d; b1_q <= b1_d;
            v2_q <= v2_d; fx2_q <= fx2_d; a2_q <= a2_d; p0_q <= p0_d; p1_q <= p1_d;
            v3_q <= v3_d; out_q <= out_d;
         end
      end
   assign px.pix_ready = adv;
   assign px.out_valid = v3_q;
   assign px.out_color = out_q;
`ifdef SPECIAL_COLOR_PIPE_STATS_EN
   logic        fx3_q, fx3_d;
   logic [15:0] blend_q, blend_d;
   always_comb begin
      fx3_d   = fx2_q != FX_NONE;
      blend_d = line_start ? 16'd0 :
                (v3_q && px.out_ready && fx3_q && blend_q != 16'hFFFF) ? blend_q + 16'd1 : blend_q;
   end
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         fx3_q   <= 1'b0;
         blend_q <= '0;
      end else begin
         blend_q <= blend_d;
         if (adv) fx3_q <= fx3_d;
      end
   assign blend_count = blend_q;
`else
   assign blend_count = '0;
`endif
endmodule

// File: tb/tb_special_color_pipe.sv
// tb_special_color_pipe: randomized + directed scoreboard bench for special_color_pipe.
module tb_special_color_pipe;
   localparam int CH_W = 5, NUM_CH = 3, W = CH_W * NUM_CH;
`ifdef SPECIAL_COLOR_PIPE_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif
   typedef struct {logic [W-1:0] c; bit fx; int cyc; bit lat;} exp_t;
   logic        clock = 1'b0, reset = 1'b0, line_start = 1'b0;
   logic [2:0]  cfg_we = '0;
   logic [15:0] cfg_data = '0, blend_count;
   special_color_pipe_if #(.CH_W(CH_W), .NUM_CH(NUM_CH)) px();
   special_color_pipe #(.CH_W(CH_W), .NUM_CH(NUM_CH), .COEF_W(5)) dut (
      .clock(clock), .reset(reset), .cfg_we(cfg_we), .cfg_data(cfg_data),
      .line_start(line_start), .px(px), .blend_count(blend_count)
   );
   always #5 clock = ~clock;
   exp_t        sb[$];
   int          total = 0, passed = 0, cyc = 0, m_cnt = 0;
   logic [15:0] m_sh[3] = '{default: '0}, m_ac[3] = '{default: '0};
   bit          dir_on = 1'b0, rand_on = 1'b0;
   logic [W-1:0] dir_exp = '0;
   always @(posedge clock) cyc <= cyc + 1;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask
   // Effect rules written directly from the layer-target / mode table
   function automatic void ref_px(input logic [15:0] cnt, al, y, input int tid, bid,
                                  input bit semi, win, input logic [W-1:0] c0, c1,
                                  output logic [W-1:0] r, output bit fx);
      bit t1, t2;
      int mode, eva, evb, evy, kind, a, b, v;
      t1 = tid < 6 && cnt[tid];
      t2 = bid < 6 && cnt[8 + bid];
      mode = int'(cnt[7:6]);
      eva = al[4:0] > 16 ? 16 : int'(al[4:0]);
      evb = al[12:8] > 16 ? 16 : int'(al[12:8]);
      evy = y[4:0] > 16 ? 16 : int'(y[4:0]);
      if (semi && t2) kind = 1;
      else if (!(t1 && win)) kind = 0;
      else case (mode)
         1: kind = t2 ? 1 : 0;
         2: kind = 2;
         3: kind = 3;
         default: kind = 0;
      endcase
      r = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         a = int'(c0[k*CH_W +: CH_W]);
         b = int'(c1[k*CH_W +: CH_W]);
         case (kind)
            1: begin v = (a * eva + b * evb) / 16; if (v > 31) v = 31; end
            2: v = a + ((31 - a) * evy) / 16;
            3: v = a - (a * evy) / 16;
            default: v = a;
         endcase
         r[k*CH_W +: CH_W] = 5'(v);
      end
      fx = kind != 0;
   endfunction
   always @(negedge clock) begin
      logic [W-1:0] r;
      bit fx;
      if (reset) begin
         sb.delete();
         m_sh = '{default: '0};
         m_ac = '{default: '0};
      end else begin
         if (px.pix_valid && px.pix_ready) begin
            ref_px(m_ac[0], m_ac[1], m_ac[2], int'(px.top_id), int'(px.bot_id), px.top_semi,
                   px.win_fx, px.color0, px.color1, r, fx);
            sb.push_back('{dir_on ? dir_exp : r, fx, cyc, dir_on});
         end
         for (int i = 0; i < 3; i++) if (cfg_we[i]) m_sh[i] = cfg_data;
         if (line_start) m_ac = m_sh;
      end
   end
   always @(negedge clock) begin
      exp_t e;
      if (reset) m_cnt = 0;
      else begin
         chk("pix_ready", px.pix_ready, !px.out_valid || px.out_ready);
         chk("blend_count", blend_count, m_cnt);
         if (px.out_valid && px.out_ready) begin
            if (sb.size() == 0) chk("unexpected_out", px.out_valid, 0);
            else begin
               e = sb.pop_front();
               chk("out_color", px.out_color, e.c);
               if (e.lat) chk("latency", cyc - e.cyc, 3);
               if (STATS && e.fx && m_cnt < 65535) m_cnt++;
            end
         end
         if (STATS && line_start) m_cnt = 0;
      end
   end
   task automatic tick();
      @(posedge clock);
      #1;
   endtask
   task automatic cfg(input logic [2:0] we, input logic [15:0] d, input bit ls);
      cfg_we = we; cfg_data = d; line_start = ls;
      tick();
      cfg_we = '0; line_start = 1'b0;
   endtask
   task automatic send(input int tid, bid, input bit semi, win, input logic [W-1:0] c0, c1,
                       input bit d, input logic [W-1:0] de);
      int n;
      bit acc;
      n = 0;
      px.pix_valid = 1'b1; px.top_id = 3'(tid); px.bot_id = 3'(bid);
      px.top_semi = semi; px.win_fx = win; px.color0 = c0; px.color1 = c1;
      dir_on = d; dir_exp = de;
      do begin
         @(negedge clock);
         acc = px.pix_ready;
         tick();
         n++;
      end while (!acc && n < 200);
      if (!acc) begin
         total++;
         $display("FAIL send_timeout: pix_ready held 0 for %0d cycles, required 1", n);
      end
      px.pix_valid = 1'b0; dir_on = 1'b0;
   endtask
   task automatic drain();
      int n;
      n = 0;
      px.out_ready = 1'b1;
      while (sb.size() != 0 && n < 100) begin tick(); n++; end
      chk("drained", sb.size(), 0);
   endtask
   task automatic rsend();
      send(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), W'($urandom), W'($urandom), 1'b0, '0);
   endtask
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
   initial begin
      px.pix_valid = 1'b0; px.top_id = '0; px.bot_id = '0; px.top_semi = 1'b0;
      px.win_fx = 1'b0; px.color0 = '0; px.color1 = '0; px.out_ready = 1'b1;
      #1 reset = 1'b1;
      repeat (2) @(negedge clock);
      chk("rst_pix_ready", px.pix_ready, 1);
      chk("rst_out_valid", px.out_valid, 0);
      chk("rst_out_color", px.out_color, 0);
      chk("rst_blend", blend_count, 0);
      tick();
      reset = 1'b0;
      tick();
      // alpha 31 over 0 at 8/8
      cfg(3'b001, 16'h0141, 1'b0);
      cfg(3'b010, 16'h0808, 1'b1);
      send(0, 0, 1'b0, 1'b1, 15'h7FFF, 15'h0000, 1'b1, 15'h3DEF);
      drain();
      // coefficient clamp, brighten to max, darken by half, no-target ids
      cfg(3'b010, 16'h1414, 1'b1);
      send(0, 0, 1'b0, 1'b1, 15'h7FFF, 15'h7FFF, 1'b1, 15'h7FFF);
      cfg(3'b001, 16'h0081, 1'b0);
      cfg(3'b100, 16'h0010, 1'b1);
      send(0, 0, 1'b0, 1'b1, 15'h0000, 15'h0000, 1'b1, 15'h7FFF);
      cfg(3'b001, 16'h00C1, 1'b0);
      cfg(3'b100, 16'h0008, 1'b1);
      send(0, 0, 1'b0, 1'b1, 15'h5294, 15'h0000, 1'b1, 15'h294A);
      send(6, 0, 1'b0, 1'b1, 15'h5294, 15'h0000, 1'b1, 15'h5294);
      send(0, 0, 1'b0, 1'b0, 15'h5294, 15'h0000, 1'b1, 15'h5294);
      drain();
      // semi-transparent OBJ overrides mode 0 and window
      cfg(3'b001, 16'h0100, 1'b0);
      cfg(3'b010, 16'h0808, 1'b1);
      send(4, 0, 1'b1, 1'b0, 15'h7FFF, 15'h0000, 1'b1, 15'h3DEF);
      send(4, 1, 1'b1, 1'b0, 15'h7FFF, 15'h0000, 1'b1, 15'h7FFF);
      drain();
      // shadow vs active, in-flight isolation, write+line_start same cycle
      cfg(3'b001, 16'h00C1, 1'b0);
      cfg(3'b100, 16'h0008, 1'b1);
      cfg(3'b100, 16'h0010, 1'b0);
      send(0, 0, 1'b0, 1'b1, 15'h5294, 15'h0000, 1'b1, 15'h294A);
      send(0, 0, 1'b0, 1'b1, 15'h5294, 15'h0000, 1'b1, 15'h294A);
      cfg(3'b000, 16'h0000, 1'b1);
      send(0, 0, 1'b0, 1'b1, 15'h5294, 15'h0000, 1'b1, 15'h0000);
      cfg(3'b100, 16'h0008, 1'b1);
      send(0, 0, 1'b0, 1'b1, 15'h5294, 15'h0000, 1'b1, 15'h294A);
      drain();
      // stats: 4 effected, 2 untouched
      cfg(3'b000, 16'h0000, 1'b1);
      repeat (4) send(0, 0, 1'b0, 1'b1, W'($urandom), W'($urandom), 1'b0, '0);
      repeat (2) send(3, 0, 1'b0, 1'b1, W'($urandom), W'($urandom), 1'b0, '0);
      drain();
      chk("stats_count", blend_count, STATS ? 4 : 0);
      cfg(3'b000, 16'h0000, 1'b1);
      chk("stats_clear", blend_count, 0);
      // backpressure mid-stream
      fork
         repeat (10) send(0, 0, 1'b0, 1'b1, W'($urandom), W'($urandom), 1'b0, '0);
         begin
            repeat (4) tick();
            px.out_ready = 1'b0;
            repeat (5) begin @(negedge clock); chk("stall_ready", px.pix_ready, 0); tick(); end
            px.out_ready = 1'b1;
         end
      join
      drain();
      // reset with pixels stuck in the pipe
      px.out_ready = 1'b0;
      repeat (3) rsend();
      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
      px.out_ready = 1'b1;
      @(negedge clock);
      chk("post_rst_valid", px.out_valid, 0);
      repeat (10) tick();
      // random traffic with random backpressure and config
      rand_on = 1'b1;
      fork
         begin
            for (int i = 0; i < 400; i++)
               if ($urandom_range(0, 7) == 0)
                  cfg(3'($urandom_range(0, 7)), 16'($urandom), 1'($urandom_range(0, 1)));
               else rsend();
            rand_on = 1'b0;
         end
         while (rand_on) begin
            px.out_ready = $urandom_range(0, 3) != 0;
            tick();
         end
      join
      drain();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
